octree_sram_arbiter: RTL and testbench

Shares the single-port octree node SRAM between the searcher and the updater. Per-access request/grant handshakes, ownership gated by the octree controller's memory-select code, lock support for read-modify-write, and return of each read to the requester that issued it. Sits between the octree controller, the searcher, the updater and the SRAM macro.

---
 rtl/octree_pkg.sv | 42 ++++
 rtl/octree_rd_tag_pipe.sv | 35 +++
 rtl/octree_sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_octree_sram_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octree_pkg.sv
// Shared octree definitions: memory-select codes, requester ids, lock states.
package octree_pkg;

   // Ownership mode driven by the octree controller.
   typedef enum logic [1:0] {
      MSEL_NAN      = 2'd0,
      MSEL_SEARCHER = 2'd1,
      MSEL_UPDATER  = 2'd2,
      MSEL_BOTH     = 2'd3
   } mem_sel_t;

   // Requester identity, also carried down the read-return tag pipe.
   typedef enum logic {
      REQ_S = 1'b0,
      REQ_U = 1'b1
   } req_id_t;

   // Ownership lock held across a read-modify-write sequence.
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK_S   = 2'd1,
      LOCK_U   = 2'd2
   } lock_state_t;

   // True when the current mode lets requester 'id' own the SRAM.
   function automatic logic is_eligible(input mem_sel_t sel, input req_id_t id);
      logic ok;
      case (sel)
         MSEL_SEARCHER: ok = (id == REQ_S);
         MSEL_UPDATER:  ok = (id == REQ_U);
         MSEL_BOTH:     ok = 1'b1;
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Lock state entered when requester 'id' takes the lock.
   function automatic lock_state_t lock_of(input req_id_t id);
      return (id == REQ_S) ? LOCK_S : LOCK_U;
   endfunction

endpackage

// File: rtl/octree_rd_tag_pipe.sv
// Read-return tag pipeline: one {valid, id} stage per cycle between accept
// and the cycle the SRAM read data is presented (1 + RD_LAT stages).
module octree_rd_tag_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic push_vld,
   input  logic push_id,
   output logic tail_vld,
   output logic tail_id,
   output logic any_vld
);

   localparam int DEPTH = RD_LAT + 1;

   logic [DEPTH-1:0] vld_p;
   logic [DEPTH-1:0] id_p;

   // Shift tags one stage per cycle; reset drops every in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
         id_p  <= '0;
      end else begin
         vld_p <= {vld_p[DEPTH-2:0], push_vld};
         id_p  <= {id_p[DEPTH-2:0], push_id};
      end
   end

   assign tail_vld = vld_p[DEPTH-1];
   assign tail_id  = id_p[DEPTH-1];
   assign any_vld  = |vld_p;

endmodule

// File: rtl/octree_sram_arbiter.sv
// Arbiter sharing the single-port octree node SRAM between the searcher and
// the updater: mode-gated eligibility, round-robin tie break, lock for
// read-modify-write, registered issue and per-requester read return.
module octree_sram_arbiter
   import octree_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mem_select,
   input  logic              s_req,
   input  logic              s_we,
   input  logic              s_lock,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_wdata,
   output logic              s_gnt,
   output logic              s_rvalid,
   output logic [DATA_W-1:0] s_rdata,
   input  logic              u_req,
   input  logic              u_we,
   input  logic              u_lock,
   input  logic [ADDR_W-1:0] u_addr,
   input  logic [DATA_W-1:0] u_wdata,
   output logic              u_gnt,
   output logic              u_rvalid,
   output logic [DATA_W-1:0] u_rdata,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              busy
);

   mem_sel_t    sel;
   logic        s_elig;
   logic        u_elig;
   logic        s_cand;
   logic        u_cand;
   lock_state_t lock_q;
   req_id_t     last_id_q;

   logic              accept;
   req_id_t           acc_id;
   logic              acc_we;
   logic              acc_lock;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

   logic              en_p0;
   logic              we_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [DATA_W-1:0] wdata_p0;

   logic tail_vld;
   logic tail_id;
   logic any_vld;

   assign sel    = mem_sel_t'(mem_select);
   assign s_elig = is_eligible(sel, REQ_S);
   assign u_elig = is_eligible(sel, REQ_U);
   assign s_cand = s_req & s_elig;
   assign u_cand = u_req & u_elig;

   // Grant decode: a held lock excludes the other side; otherwise a tie goes
   // to whoever was not served last.
   always_comb begin
      s_gnt = 1'b0;
      u_gnt = 1'b0;
      case (lock_q)
         LOCK_S: s_gnt = s_cand;
         LOCK_U: u_gnt = u_cand;
         default: begin
            if (s_cand && u_cand) begin
               s_gnt = (last_id_q == REQ_U);
               u_gnt = (last_id_q == REQ_S);
            end else begin
               s_gnt = s_cand;
               u_gnt = u_cand;
            end
         end
      endcase
   end

   // Mux the accepted request; grants are one-hot so u_gnt selects.
   always_comb begin
      accept    = s_gnt | u_gnt;
      acc_id    = u_gnt ? REQ_U : REQ_S;
      acc_we    = u_gnt ? u_we    : s_we;
      acc_lock  = u_gnt ? u_lock  : s_lock;
      acc_addr  = u_gnt ? u_addr  : s_addr;
      acc_wdata = u_gnt ? u_wdata : s_wdata;
   end

   // Lock FSM and round-robin history; a lock is dropped as soon as the mode
   // no longer lets its owner access the SRAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q    <= UNLOCKED;
         last_id_q <= REQ_U;
      end else if (accept) begin
         last_id_q <= acc_id;
         lock_q    <= acc_lock ? lock_of(acc_id) : UNLOCKED;
      end else begin
         case (lock_q)
            LOCK_S:  if (!s_elig) lock_q <= UNLOCKED;
            LOCK_U:  if (!u_elig) lock_q <= UNLOCKED;
            default: lock_q <= UNLOCKED;
         endcase
      end
   end

   // ---- stage p0: accepted access presented to the SRAM for one cycle ----
   // Issue registers; address/data hold their last value when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_p0    <= 1'b0;
         we_p0    <= 1'b0;
         addr_p0  <= '0;
         wdata_p0 <= '0;
      end else begin
         en_p0 <= accept;
         we_p0 <= accept & acc_we;
         if (accept) begin
            addr_p0  <= acc_addr;
            wdata_p0 <= acc_wdata;
         end
      end
   end

   assign sram_en    = en_p0;
   assign sram_we    = we_p0;
   assign sram_addr  = addr_p0;
   assign sram_wdata = wdata_p0;

   // ---- stages p0..pRD_LAT: read ownership travels with the SRAM latency ----
   octree_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .rst      (rst),
      .push_vld (accept & ~acc_we),
      .push_id  (acc_id),
      .tail_vld (tail_vld),
      .tail_id  (tail_id),
      .any_vld  (any_vld)
   );

   assign s_rvalid = tail_vld & (tail_id == REQ_S);
   assign u_rvalid = tail_vld & (tail_id == REQ_U);
   assign s_rdata  = sram_rdata;
   assign u_rdata  = sram_rdata;

   assign busy = (lock_q != UNLOCKED) | any_vld;

endmodule

// File: tb/tb_octree_sram_arbiter.sv
// Self-checking bench for octree_sram_arbiter: grant truth table, directed
// corner sequences and randomized traffic against a transaction-level model.
module tb_octree_sram_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;
   localparam int RD_LAT = 3;
   localparam int NWORDS = 1 << ADDR_W;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [1:0]        mem_select;
   logic              s_req, s_we, s_lock, s_gnt, s_rvalid;
   logic              u_req, u_we, u_lock, u_gnt, u_rvalid;
   logic [ADDR_W-1:0] s_addr, u_addr, sram_addr;
   logic [DATA_W-1:0] s_wdata, u_wdata, s_rdata, u_rdata, sram_wdata, sram_rdata;
   logic              sram_en, sram_we, busy;

   octree_sram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_select (mem_select),
      .s_req      (s_req),
      .s_we       (s_we),
      .s_lock     (s_lock),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_gnt      (s_gnt),
      .s_rvalid   (s_rvalid),
      .s_rdata    (s_rdata),
      .u_req      (u_req),
      .u_we       (u_we),
      .u_lock     (u_lock),
      .u_addr     (u_addr),
      .u_wdata    (u_wdata),
      .u_gnt      (u_gnt),
      .u_rvalid   (u_rvalid),
      .u_rdata    (u_rdata),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .busy       (busy)
   );

   int checks   = 0;
   int failures = 0;

   // SRAM macro model
   logic [DATA_W-1:0] mem     [NWORDS];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   assign sram_rdata = rd_pipe[RD_LAT-1];

   // Reference model: memory image, owner of the lock (0 none, 1 S, 2 U),
   // last winner (0 S, 1 U), expected issue and outstanding read returns.
   typedef struct {
      int                due;
      bit                id;
      logic [DATA_W-1:0] data;
   } ret_t;

   logic [DATA_W-1:0] ref_mem [NWORDS];
   ret_t              ret_q[$];
   int                m_lock;
   bit                m_last;
   bit                m_gs, m_gu;
   bit                x_en, x_we;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_wdata;
   int                cyc;

   typedef struct {
      logic [1:0] msel;
      logic       sr;
      logic       ur;
      logic       es;
      logic       eu;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit elig_s();
      return (mem_select == 2'd1) || (mem_select == 2'd3);
   endfunction

   function automatic bit elig_u();
      return (mem_select == 2'd2) || (mem_select == 2'd3);
   endfunction

   // Who should be granted right now, from the ownership rules.
   task automatic model_gnt(output bit gs, output bit gu);
      bit sc, uc;
      sc = s_req && elig_s();
      uc = u_req && elig_u();
      gs = 0;
      gu = 0;
      if (m_lock == 1) gs = sc;
      else if (m_lock == 2) gu = uc;
      else if (sc && uc) begin
         gs = (m_last == 1);
         gu = (m_last == 0);
      end else begin
         gs = sc;
         gu = uc;
      end
   endtask

   // One clock cycle: compare every output against the model, advance the
   // SRAM model and the reference model, then return just after the edge.
   task automatic tick();
      bit gs, gu, rs, ru, acc, id, we, lk;
      logic [DATA_W-1:0] rdat;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      @(negedge clk);
      while (ret_q.size() > 0 && ret_q[0].due < cyc) void'(ret_q.pop_front());
      model_gnt(gs, gu);
      chk("s_gnt", s_gnt, gs);
      chk("u_gnt", u_gnt, gu);
      chk("sram_en", sram_en, x_en);
      if (x_en) begin
         chk("sram_we", sram_we, x_we);
         chk("sram_addr", sram_addr, x_addr);
         if (x_we) chk("sram_wdata", sram_wdata, x_wdata);
      end
      rs = 0; ru = 0; rdat = '0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
         rs   = (ret_q[0].id == 0);
         ru   = (ret_q[0].id == 1);
         rdat = ret_q[0].data;
      end
      chk("s_rvalid", s_rvalid, rs);
      chk("u_rvalid", u_rvalid, ru);
      if (rs) chk("s_rdata", s_rdata, rdat);
      if (ru) chk("u_rdata", u_rdata, rdat);
      chk("busy", busy, (m_lock != 0) || (ret_q.size() > 0));

      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      if (sram_en && !sram_we) rd_pipe[0] = mem[sram_addr];
      if (sram_en && sram_we) mem[sram_addr] = sram_wdata;

      m_gs = gs;
      m_gu = gu;
      if (rst) begin
         m_lock = 0;
         m_last = 1;
         ret_q.delete();
         x_en = 0;
         x_we = 0;
      end else begin
         acc = gs || gu;
         id  = gu;
         if (acc) begin
            we = id ? u_we : s_we;
            lk = id ? u_lock : s_lock;
            a  = id ? u_addr : s_addr;
            wd = id ? u_wdata : s_wdata;
            x_en = 1; x_we = we; x_addr = a; x_wdata = wd;
            if (we) ref_mem[a] = wd;
            else ret_q.push_back('{cyc + 1 + RD_LAT, id, ref_mem[a]});
            m_last = id;
            m_lock = lk ? (id ? 2 : 1) : 0;
         end else begin
            x_en = 0;
            x_we = 0;
            if (m_lock == 1 && !elig_s()) m_lock = 0;
            if (m_lock == 2 && !elig_u()) m_lock = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_req = 0; s_we = 0; s_lock = 0;
      u_req = 0; u_we = 0; u_lock = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle();
      tick();
      rst = 0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < RD_LAT + 2; i++) tick();
   endtask

   initial begin
      vec_t vt[16];
      bit s_pend, u_pend;
      int pulses, first, last;

      rst = 1; mem_select = 2'd0; idle();
      s_addr = '0; u_addr = '0; s_wdata = '0; u_wdata = '0;
      cyc = 0; m_lock = 0; m_last = 1; m_gs = 0; m_gu = 0;
      x_en = 0; x_we = 0; x_addr = '0; x_wdata = '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
      for (int i = 0; i < NWORDS; i++) begin
         mem[i]     = {$urandom, $urandom};
         ref_mem[i] = mem[i];
      end

      // Grant truth table from the reset state (unlocked, searcher wins ties).
      vt[0]  = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[4]  = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[7]  = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[9]  = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[10] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[11] = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[12] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[13] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[14] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[15] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         mem_select = vt[i].msel;
         s_req      = vt[i].sr;
         u_req      = vt[i].ur;
         #1;
         chk($sformatf("tbl%0d_s_gnt", i), s_gnt, vt[i].es);
         chk($sformatf("tbl%0d_u_gnt", i), u_gnt, vt[i].eu);
      end
      idle();
      mem_select = 2'd0;
      @(posedge clk);
      #1;
      do_reset();

      // Read return to the searcher, then a read killed by reset.
      mem[5] = 64'hA5; ref_mem[5] = 64'hA5;
      mem_select = 2'd1;
      s_req = 1; s_we = 0; s_addr = 10'd5; s_wdata = 64'h1234; s_lock = 0;
      #1;
      chk("rmr_s_gnt", s_gnt, 1);
      tick();
      s_req = 0;
      #1;
      chk("rmr_sram_en", sram_en, 1);
      chk("rmr_sram_addr", sram_addr, 5);
      chk("rmr_sram_we", sram_we, 0);
      for (int i = 0; i < RD_LAT; i++) tick();
      chk("rmr_s_rvalid", s_rvalid, 1);
      chk("rmr_s_rdata", s_rdata, 64'hA5);
      chk("rmr_u_rvalid", u_rvalid, 0);
      tick();
      s_req = 1;
      tick();
      s_req = 0;
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk("rst_sram_en", sram_en, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_wdata", sram_wdata, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < RD_LAT + 1; i++) begin
         chk("rst_no_s_rvalid", s_rvalid, 0);
         chk("rst_no_u_rvalid", u_rvalid, 0);
         tick();
      end

      // Round-robin between continuous requesters.
      do_reset();
      mem_select = 2'd3;
      s_req = 1; u_req = 1; s_addr = 10'd1; u_addr = 10'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_s_gnt", s_gnt, (i % 2) == 0);
         chk("rr_u_gnt", u_gnt, (i % 2) == 1);
         tick();
      end
      drain();

      // Mode gating.
      do_reset();
      mem_select = 2'd0;
      s_req = 1; u_req = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("nan_s_gnt", s_gnt, 0);
         chk("nan_u_gnt", u_gnt, 0);
         chk("nan_sram_en", sram_en, 0);
         tick();
      end
      mem_select = 2'd2;
      #1;
      chk("upd_u_gnt", u_gnt, 1);
      chk("upd_s_gnt", s_gnt, 0);
      tick();
      drain();

      // Read-modify-write lock held by the updater.
      do_reset();
      mem_select = 2'd3;
      u_req = 1; u_we = 0; u_addr = 10'd9; u_lock = 1;
      #1;
      chk("lk_u_gnt", u_gnt, 1);
      tick();
      u_req = 0; u_lock = 0;
      s_req = 1; s_we = 0; s_addr = 10'd3;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("lk_s_blocked", s_gnt, 0);
         chk("lk_busy", busy, 1);
         tick();
      end
      u_req = 1; u_we = 1; u_addr = 10'd9; u_wdata = 64'hBEEF; u_lock = 0;
      #1;
      chk("lk_u_wr_gnt", u_gnt, 1);
      chk("lk_s_still_blocked", s_gnt, 0);
      chk("lk_busy_wr", busy, 1);
      tick();
      u_req = 0;
      #1;
      chk("lk_s_released", s_gnt, 1);
      chk("lk_busy_after", busy, 1);
      tick();
      drain();

      // Lock revoked by a mode change while a searcher read is in flight.
      do_reset();
      mem[4] = 64'h44; ref_mem[4] = 64'h44;
      mem_select = 2'd1;
      s_req = 1; s_we = 0; s_addr = 10'd4; s_lock = 1;
      #1;
      chk("rv_s_gnt", s_gnt, 1);
      tick();
      mem_select = 2'd2;
      s_req = 1; s_lock = 0; s_addr = 10'd7;
      u_req = 1; u_we = 0; u_addr = 10'd6;
      #1;
      chk("rv_s_gnt_off", s_gnt, 0);
      chk("rv_u_gnt_locked", u_gnt, 0);
      chk("rv_busy", busy, 1);
      tick();
      #1;
      chk("rv_u_gnt", u_gnt, 1);
      tick();
      idle();
      tick();
      chk("rv_s_rvalid", s_rvalid, 1);
      chk("rv_s_rdata", s_rdata, 64'h44);
      chk("rv_u_rvalid", u_rvalid, 0);
      tick();
      drain();

      // Back-to-back reads: consecutive returns, busy falls right after.
      do_reset();
      mem_select = 2'd1;
      pulses = 0; first = -1; last = -1;
      for (int i = 0; i < 13; i++) begin
         if (i < 8) begin
            s_req  = 1;
            s_we   = 0;
            s_addr = ((i % 2) == 0) ? 10'd10 : 10'd11;
         end else begin
            s_req = 0;
         end
         #1;
         if (i < 8) chk("tp_s_gnt", s_gnt, 1);
         if (s_rvalid) begin
            pulses++;
            if (first < 0) first = i;
            last = i;
         end
         if (i == 11) chk("tp_busy_last", busy, 1);
         if (i == 12) chk("tp_busy_fall", busy, 0);
         tick();
      end
      chk("tp_pulses", pulses, 8);
      chk("tp_first", first, 4);
      chk("tp_consecutive", last - first, 7);

      // Randomized traffic; requesters hold their request until granted.
      do_reset();
      s_pend = 0; u_pend = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(15) == 0) mem_select = 2'($urandom_range(3));
         if (!s_pend && $urandom_range(2) == 0) begin
            s_pend  = 1;
            s_we    = 1'($urandom_range(1));
            s_addr  = 10'($urandom_range(15));
            s_wdata = {$urandom, $urandom};
            s_lock  = ($urandom_range(3) == 0);
         end
         if (!u_pend && $urandom_range(2) == 0) begin
            u_pend  = 1;
            u_we    = 1'($urandom_range(1));
            u_addr  = 10'($urandom_range(15));
            u_wdata = {$urandom, $urandom};
            u_lock  = ($urandom_range(3) == 0);
         end
         s_req = s_pend;
         u_req = u_pend;
         rst   = ($urandom_range(199) == 0);
         tick();
         if (m_gs) s_pend = 0;
         if (m_gu) u_pend = 0;
      end
      rst = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
